// File: rtl/handshake_pkg.sv
// -----------------------------------------------------------------------------
// handshake_pkg
// Shared definitions for the handshake_* dataflow channel units.
//   CHANNEL_WIDTH : default payload width of a channel
//   MIN_SLOTS     : smallest legal elastic FIFO depth
//   MAX_SLOTS     : largest legal elastic FIFO depth
//   hs_clog2()    : ceil(log2(n)), usable in parameter/localparam expressions
// -----------------------------------------------------------------------------
package handshake_pkg;

   localparam int unsigned CHANNEL_WIDTH = 32;
   localparam int unsigned MIN_SLOTS     = 2;
   localparam int unsigned MAX_SLOTS     = 64;

   // Bits needed to encode the values 0..n-1 (0 for n <= 1).
   function automatic int unsigned hs_clog2(input int unsigned n);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/handshake_fifo_ptr.sv
// -----------------------------------------------------------------------------
// handshake_fifo_ptr
// Wrap-around pointer counter for a FIFO of NUM_SLOTS entries. The counter
// returns to 0 after NUM_SLOTS-1, so depths need not be a power of two.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears ptr to 0
//   inc  : advance the pointer by one slot this cycle
//   ptr  : current slot index, hs_clog2(NUM_SLOTS) bits
// -----------------------------------------------------------------------------
module handshake_fifo_ptr
   import handshake_pkg::*;
#(
   parameter  int unsigned NUM_SLOTS = 4,
   localparam int unsigned PTR_W     = hs_clog2(NUM_SLOTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (inc) begin
         ptr_d = (ptr_q == LAST_SLOT) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/handshake_elastic_fifo.sv
// -----------------------------------------------------------------------------
// handshake_elastic_fifo
// Elastic FIFO for dataflow channels. outs/outs_valid come from registered
// storage and ins_ready depends only on the registered occupancy, cutting both
// the forward valid path and the backward ready path.
// A transfer happens on a rising edge where valid and ready are both high.
// Ports:
//   clk, rst   : clock; asynchronous active-high reset (clears all state)
//   ins        : upstream payload, DATA_WIDTH bits
//   ins_valid  : upstream valid
//   ins_ready  : high while count != NUM_SLOTS
//   outs       : downstream payload, slot[head]
//   outs_valid : high while count != 0
//   outs_ready : downstream ready
// Build option:
//   HANDSHAKE_FIFO_BYPASS_EN : when defined, an empty FIFO forwards ins to
//   outs combinationally; a token taken by downstream in that same cycle is
//   never written into storage.
// -----------------------------------------------------------------------------
module handshake_elastic_fifo
   import handshake_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CHANNEL_WIDTH,
   parameter int unsigned NUM_SLOTS  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready
);

   localparam int unsigned      PTR_W    = hs_clog2(NUM_SLOTS);
   localparam int unsigned      CNT_W    = hs_clog2(NUM_SLOTS + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

   if (NUM_SLOTS < MIN_SLOTS || NUM_SLOTS > MAX_SLOTS) begin : g_bad_depth
      $error("handshake_elastic_fifo: NUM_SLOTS=%0d outside %0d..%0d",
             NUM_SLOTS, MIN_SLOTS, MAX_SLOTS);
   end

   logic [DATA_WIDTH-1:0] slot_q [NUM_SLOTS];
   logic [DATA_WIDTH-1:0] slot_d [NUM_SLOTS];
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic                  empty;
   logic                  bypass;
   logic                  push_store;
   logic                  pop_store;

   assign empty     = (count_q == '0);
   assign ins_ready = (count_q != FULL_CNT);

`ifdef HANDSHAKE_FIFO_BYPASS_EN
   assign outs_valid = !empty || ins_valid;
   assign outs       = empty ? ins : slot_q[head];
   // Token handed straight through to a ready consumer: storage is untouched.
   assign bypass     = empty && ins_valid && outs_ready;
`else
   assign outs_valid = !empty;
   assign outs       = slot_q[head];
   assign bypass     = 1'b0;
`endif

   assign push_store = ins_valid && ins_ready && !bypass;
   assign pop_store  = !empty && outs_ready;

   always_comb begin
      slot_d = slot_q;
      if (push_store) begin
         slot_d[tail] = ins;
      end
   end

   always_comb begin
      count_d = count_q;
      if (push_store && !pop_store) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_store && pop_store) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         slot_q  <= '{default: '0};
      end else begin
         count_q <= count_d;
         slot_q  <= slot_d;
      end
   end

   handshake_fifo_ptr #(
      .NUM_SLOTS(NUM_SLOTS)
   ) u_head_ptr (
      .clk(clk),
      .rst(rst),
      .inc(pop_store),
      .ptr(head)
   );

   handshake_fifo_ptr #(
      .NUM_SLOTS(NUM_SLOTS)
   ) u_tail_ptr (
      .clk(clk),
      .rst(rst),
      .inc(push_store),
      .ptr(tail)
   );

endmodule
